// File: rtl/emc_xmem_pkg.sv
// Shared definitions for the EMC08 external SRAM controller: FSM state
// encodings, wait-counter width, a counter-load helper and the parameter
// range-check macro. Compile this file first. Optional feature macro used by
// the controller: EMC_XMEM_WBUF_EN.
`ifndef EMC_XMEM_PKG_SV
`define EMC_XMEM_PKG_SV

`define EMC_XMEM_IN_RANGE(v, lo, hi) (((v) >= (lo)) && ((v) <= (hi)))

package emc_xmem_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4
  } xmem_state_e;

  // Truncate a configuration value to the wait-counter width.
  function automatic logic [CNT_W-1:0] cnt_val(input int v);
    return CNT_W'(v);
  endfunction

endpackage

`endif

// File: rtl/emc_xmem_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag. Counts down to zero and stays
// there; it never wraps past the loaded value.
module emc_xmem_wait_cnt
  import emc_xmem_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/emc_xmem_ctrl.sv
// EMC08 external SRAM bus controller. Converts a CPU req/ack handshake into
// SETUP / ACCESS / HOLD / TURN strobe sequencing with programmable read and
// write wait states and read-to-next-access bus turnaround.
// Optional feature macro: EMC_XMEM_WBUF_EN (single-entry posted-write buffer;
// writes are acknowledged the cycle after acceptance).
module emc_xmem_ctrl
  import emc_xmem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 1,
  parameter int TURN    = 1
) (
  input  logic              xmc_clock_i,
  input  logic              xmc_reset_i,
  input  logic              xmc_req_i,
  input  logic              xmc_we_i,
  input  logic [ADDR_W-1:0] xmc_addr_i,
  input  logic [DATA_W-1:0] xmc_wdata_i,
  output logic              xmc_ack_o,
  output logic [DATA_W-1:0] xmc_rdata_o,
  output logic              xmc_busy_o,
  output logic [ADDR_W-1:0] xmc_mem_a_o,
  output logic [DATA_W-1:0] xmc_mem_d_o,
  input  logic [DATA_W-1:0] xmc_mem_d_i,
  output logic              xmc_mem_d_en_o,
  output logic              xmc_mem_ce_b_o,
  output logic              xmc_mem_we_b_o,
  output logic              xmc_mem_oe_b_o
);

  // Elaboration-time parameter checks.
  if (!`EMC_XMEM_IN_RANGE(ADDR_W, 8, 24)) begin : g_bad_addr_w
    $error("emc_xmem_ctrl: ADDR_W must be 8..24");
  end
  if (!((DATA_W == 8) || (DATA_W == 16))) begin : g_bad_data_w
    $error("emc_xmem_ctrl: DATA_W must be 8 or 16");
  end
  if (!`EMC_XMEM_IN_RANGE(WAIT_RD, 0, 15)) begin : g_bad_wait_rd
    $error("emc_xmem_ctrl: WAIT_RD must be 0..15");
  end
  if (!`EMC_XMEM_IN_RANGE(WAIT_WR, 0, 15)) begin : g_bad_wait_wr
    $error("emc_xmem_ctrl: WAIT_WR must be 0..15");
  end
  if (!`EMC_XMEM_IN_RANGE(TURN, 0, 3)) begin : g_bad_turn
    $error("emc_xmem_ctrl: TURN must be 0..3");
  end

  // The TURN state reuses the wait counter: TURN cycles means load TURN-1.
  localparam logic [CNT_W-1:0] TURN_LD = (TURN > 0) ? cnt_val(TURN - 1) : '0;

  xmem_state_e       r_state;
  xmem_state_e       w_next;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              w_accept;
  logic              w_cnt_load;
  logic [CNT_W-1:0]  w_cnt_val;
  logic              w_cnt_dec;
  logic              w_cnt_zero;

`ifdef EMC_XMEM_WBUF_EN
  logic r_wbuf_vld;

  // Posted-write occupancy: set on write acceptance, freed once its HOLD ends.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      r_wbuf_vld <= 1'b0;
    end else if (w_accept && xmc_we_i) begin
      r_wbuf_vld <= 1'b1;
    end else if (r_state == ST_HOLD) begin
      r_wbuf_vld <= 1'b0;
    end
  end

  assign w_accept = (r_state == ST_IDLE) && xmc_req_i && !r_wbuf_vld;
`else
  assign w_accept = (r_state == ST_IDLE) && xmc_req_i;
`endif

  // State register; reset aborts any access in flight.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing IDLE -> SETUP -> ACCESS -> HOLD -> (TURN | IDLE).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_SETUP;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_cnt_zero) w_next = ST_HOLD;
      ST_HOLD:   w_next = (!r_we && (TURN > 0)) ? ST_TURN : ST_IDLE;
      ST_TURN:   if (w_cnt_zero) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Counter control: wait states loaded in SETUP, turnaround loaded in HOLD.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_SETUP: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = r_we ? cnt_val(WAIT_WR) : cnt_val(WAIT_RD);
      end
      ST_HOLD: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = TURN_LD;
      end
      ST_ACCESS, ST_TURN: w_cnt_dec = 1'b1;
      default: ;
    endcase
  end

  emc_xmem_wait_cnt u_wait_cnt (
    .i_clk      (xmc_clock_i),
    .i_rst_n    (xmc_reset_i),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Request capture in IDLE only, so address/data cannot move while CE is low.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= xmc_we_i;
      r_addr  <= xmc_addr_i;
      r_wdata <= xmc_wdata_i;
    end
  end

  // Read data captured on the last ACCESS cycle; held until the next read.
  always_ff @(posedge xmc_clock_i or negedge xmc_reset_i) begin
    if (!xmc_reset_i) begin
      r_rdata <= '0;
    end else if ((r_state == ST_ACCESS) && w_cnt_zero && !r_we) begin
      r_rdata <= xmc_mem_d_i;
    end
  end

  // Strobe, enable and acknowledge decode from the current state.
  always_comb begin
    xmc_busy_o     = (r_state != ST_IDLE);
    xmc_mem_ce_b_o = 1'b1;
    xmc_mem_we_b_o = 1'b1;
    xmc_mem_oe_b_o = 1'b1;
    xmc_mem_d_en_o = 1'b0;
    xmc_ack_o      = 1'b0;
    case (r_state)
      ST_SETUP: begin
        xmc_mem_ce_b_o = 1'b0;
        xmc_mem_d_en_o = r_we;
`ifdef EMC_XMEM_WBUF_EN
        xmc_ack_o      = r_we;
`endif
      end
      ST_ACCESS: begin
        xmc_mem_ce_b_o = 1'b0;
        xmc_mem_d_en_o = r_we;
        xmc_mem_we_b_o = !r_we;
        xmc_mem_oe_b_o = r_we;
      end
      ST_HOLD: begin
        xmc_mem_ce_b_o = 1'b0;
        xmc_mem_d_en_o = r_we;
`ifdef EMC_XMEM_WBUF_EN
        xmc_ack_o      = !r_we;
`else
        xmc_ack_o      = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  assign xmc_rdata_o = r_rdata;
  assign xmc_mem_a_o = r_addr;
  assign xmc_mem_d_o = r_wdata;

endmodule

// File: tb/tb_emc_xmem_ctrl.sv
// Directed testbench for emc_xmem_ctrl. Two instances: u_dut0 (WAIT_RD=1,
// WAIT_WR=0, TURN=1) and u_dut1 (WAIT_RD=0, WAIT_WR=3, TURN=0), each with a
// behavioural 64Kx8 SRAM. Honours EMC_XMEM_WBUF_EN when defined.
module tb_emc_xmem_ctrl;

`ifdef EMC_XMEM_WBUF_EN
  localparam int WR_ACK0 = 1;
  localparam int WR_ACK1 = 1;
`else
  localparam int WR_ACK0 = 3;
  localparam int WR_ACK1 = 6;
`endif

  logic        clk;
  logic        rst_n;
  int          n_checks;
  int          n_fail;
  int          viol;

  logic        d0_req, d0_we, d0_ack, d0_busy, d0_d_en, d0_ce_b, d0_we_b, d0_oe_b;
  logic [15:0] d0_addr, d0_mem_a;
  logic [7:0]  d0_wdata, d0_rdata, d0_mem_d, d0_mem_d_i;
  logic        d1_req, d1_we, d1_ack, d1_busy, d1_d_en, d1_ce_b, d1_we_b, d1_oe_b;
  logic [15:0] d1_addr, d1_mem_a;
  logic [7:0]  d1_wdata, d1_rdata, d1_mem_d, d1_mem_d_i;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];
  logic        pre0_we;
  logic [15:0] pre0_addr;
  logic [7:0]  pre0_data;

  logic        p0_ce_b, p1_ce_b;
  logic [15:0] p0_a, p1_a;
  logic [7:0]  p0_d, p1_d;

  emc_xmem_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_RD(1), .WAIT_WR(0), .TURN(1)) u_dut0 (
    .xmc_clock_i(clk), .xmc_reset_i(rst_n), .xmc_req_i(d0_req), .xmc_we_i(d0_we),
    .xmc_addr_i(d0_addr), .xmc_wdata_i(d0_wdata), .xmc_ack_o(d0_ack), .xmc_rdata_o(d0_rdata),
    .xmc_busy_o(d0_busy), .xmc_mem_a_o(d0_mem_a), .xmc_mem_d_o(d0_mem_d), .xmc_mem_d_i(d0_mem_d_i),
    .xmc_mem_d_en_o(d0_d_en), .xmc_mem_ce_b_o(d0_ce_b), .xmc_mem_we_b_o(d0_we_b),
    .xmc_mem_oe_b_o(d0_oe_b)
  );

  emc_xmem_ctrl #(.ADDR_W(16), .DATA_W(8), .WAIT_RD(0), .WAIT_WR(3), .TURN(0)) u_dut1 (
    .xmc_clock_i(clk), .xmc_reset_i(rst_n), .xmc_req_i(d1_req), .xmc_we_i(d1_we),
    .xmc_addr_i(d1_addr), .xmc_wdata_i(d1_wdata), .xmc_ack_o(d1_ack), .xmc_rdata_o(d1_rdata),
    .xmc_busy_o(d1_busy), .xmc_mem_a_o(d1_mem_a), .xmc_mem_d_o(d1_mem_d), .xmc_mem_d_i(d1_mem_d_i),
    .xmc_mem_d_en_o(d1_d_en), .xmc_mem_ce_b_o(d1_ce_b), .xmc_mem_we_b_o(d1_we_b),
    .xmc_mem_oe_b_o(d1_oe_b)
  );

  always #5 clk = ~clk;

  // SRAM models: asynchronous read while CE and OE low, write on clock while CE and WE low.
  assign d0_mem_d_i = (!d0_ce_b && !d0_oe_b) ? mem0[d0_mem_a] : 8'h00;
  assign d1_mem_d_i = (!d1_ce_b && !d1_oe_b) ? mem1[d1_mem_a] : 8'h00;

  always @(posedge clk) begin
    if (pre0_we) mem0[pre0_addr] <= pre0_data;
    else if (!d0_ce_b && !d0_we_b && d0_d_en) mem0[d0_mem_a] <= d0_mem_d;
  end

  always @(posedge clk) begin
    if (!d1_ce_b && !d1_we_b && d1_d_en) mem1[d1_mem_a] <= d1_mem_d;
  end

  // Bus protocol monitor: no WE/OE overlap, address/data frozen while CE low.
  always @(negedge clk) begin
    if ((!d0_we_b && !d0_oe_b) || (!d1_we_b && !d1_oe_b)) viol <= viol + 1;
    else if (!d0_ce_b && !p0_ce_b && ((d0_mem_a !== p0_a) || (d0_mem_d !== p0_d))) viol <= viol + 1;
    else if (!d1_ce_b && !p1_ce_b && ((d1_mem_a !== p1_a) || (d1_mem_d !== p1_d))) viol <= viol + 1;
    p0_ce_b <= d0_ce_b; p0_a <= d0_mem_a; p0_d <= d0_mem_d;
    p1_ce_b <= d1_ce_b; p1_a <= d1_mem_a; p1_d <= d1_mem_d;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload0(input logic [15:0] a, input logic [7:0] d);
    pre0_we = 1'b1; pre0_addr = a; pre0_data = d;
    tick();
    pre0_we = 1'b0;
  endtask

  // One access on u_dut0; reports ack cycle (1 = first cycle after sample) and strobe counts.
  task automatic run_access(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            output int ack_cyc, output int oe_cnt, output int we_cnt,
                            output int den_cnt);
    ack_cyc = -1; oe_cnt = 0; we_cnt = 0; den_cnt = 0;
    d0_req = 1'b1; d0_we = we; d0_addr = a; d0_wdata = wd;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!d0_oe_b) oe_cnt++;
      if (!d0_we_b) we_cnt++;
      if (d0_d_en) den_cnt++;
      if (d0_ack && (ack_cyc < 0)) begin
        ack_cyc = k;
        d0_req = 1'b0;
      end
      if ((ack_cyc >= 0) && !d0_busy) break;
    end
    d0_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (d0_ce_b !== 1'b1) begin n_fail++; $display("FAIL rst_hold_ce_b: got %b want 1", d0_ce_b); end
    n_checks++; if (d0_ack !== 1'b0) begin n_fail++; $display("FAIL rst_hold_ack: got %b want 0", d0_ack); end
    rst_n = 1'b1;
    tick();
    n_checks++; if ({d0_ce_b, d0_we_b, d0_oe_b} !== 3'b111) begin n_fail++; $display("FAIL rst_strobes: got %b want 111", {d0_ce_b, d0_we_b, d0_oe_b}); end
    n_checks++; if (d0_d_en !== 1'b0) begin n_fail++; $display("FAIL rst_d_en: got %b want 0", d0_d_en); end
    n_checks++; if (d0_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", d0_ack); end
    n_checks++; if (d0_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata: got %h want 00", d0_rdata); end
    n_checks++; if (d0_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", d0_busy); end
    n_checks++; if (d0_mem_a !== 16'h0000) begin n_fail++; $display("FAIL rst_mem_a: got %h want 0000", d0_mem_a); end
    n_checks++; if ({d1_ce_b, d1_we_b, d1_oe_b, d1_busy, d1_rdata} !== {3'b111, 1'b0, 8'h00}) begin n_fail++; $display("FAIL rst_dut1: got %b/%b/%h want 111/0/00", {d1_ce_b, d1_we_b, d1_oe_b}, d1_busy, d1_rdata); end
  endtask

  task automatic test_read_turn();
    int first, second, oe, k;
    logic [7:0] rd1, rd2;
    logic t_busy, t_ce_b, t_den;
    preload0(16'h1234, 8'hA5);
    preload0(16'h1235, 8'h5A);
    tick();
    first = -1; second = -1; oe = 0; rd1 = '0; rd2 = '0;
    t_busy = 1'b0; t_ce_b = 1'b0; t_den = 1'b1;
    d0_req = 1'b1; d0_we = 1'b0; d0_addr = 16'h1234;
    for (k = 1; k <= 25; k++) begin
      tick();
      if (!d0_oe_b) oe++;
      if ((first > 0) && (k == first + 1)) begin
        t_busy = d0_busy; t_ce_b = d0_ce_b; t_den = d0_d_en;
      end
      if (d0_ack) begin
        if (first < 0) begin
          first = k; rd1 = d0_rdata; d0_addr = 16'h1235;
        end else if (second < 0) begin
          second = k; rd2 = d0_rdata; d0_req = 1'b0;
        end
      end
      if ((second > 0) && !d0_busy) break;
    end
    d0_req = 1'b0;
    tick();
    n_checks++; if (first !== 4) begin n_fail++; $display("FAIL rd_ack_latency: got %0d want 4", first); end
    n_checks++; if (rd1 !== 8'hA5) begin n_fail++; $display("FAIL rd_data1: got %h want a5", rd1); end
    n_checks++; if ({t_busy, t_ce_b, t_den} !== 3'b110) begin n_fail++; $display("FAIL rd_turn_state: got %b want 110", {t_busy, t_ce_b, t_den}); end
    n_checks++; if (second !== 10) begin n_fail++; $display("FAIL rd_turn_next_ack: got %0d want 10", second); end
    n_checks++; if (rd2 !== 8'h5A) begin n_fail++; $display("FAIL rd_data2: got %h want 5a", rd2); end
    n_checks++; if (oe !== 4) begin n_fail++; $display("FAIL rd_oe_cycles: got %0d want 4", oe); end
  endtask

  task automatic test_write_readback();
    int ack, oe, we, den;
    run_access(1'b1, 16'h00FF, 8'h3C, ack, oe, we, den);
    n_checks++; if (ack !== WR_ACK0) begin n_fail++; $display("FAIL wr_ack_latency: got %0d want %0d", ack, WR_ACK0); end
    n_checks++; if (we !== 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d want 1", we); end
    n_checks++; if (den !== 3) begin n_fail++; $display("FAIL wr_d_en_cycles: got %0d want 3", den); end
    n_checks++; if (oe !== 0) begin n_fail++; $display("FAIL wr_oe_cycles: got %0d want 0", oe); end
    run_access(1'b0, 16'h00FF, 8'h00, ack, oe, we, den);
    n_checks++; if (ack !== 4) begin n_fail++; $display("FAIL rb_ack_latency: got %0d want 4", ack); end
    n_checks++; if (d0_rdata !== 8'h3C) begin n_fail++; $display("FAIL rb_data: got %h want 3c", d0_rdata); end
    n_checks++; if ((oe !== 2) || (den !== 0)) begin n_fail++; $display("FAIL rb_strobes: got oe %0d den %0d want 2 0", oe, den); end
  endtask

  task automatic test_reset_mid_access();
    int acks, ack, oe, we, den;
    d0_req = 1'b1; d0_we = 1'b1; d0_addr = 16'h0040; d0_wdata = 8'h77;
    tick();
    tick();
    n_checks++; if (d0_we_b !== 1'b0) begin n_fail++; $display("FAIL abort_in_access: got we_b %b want 0", d0_we_b); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({d0_ce_b, d0_we_b, d0_oe_b, d0_d_en, d0_busy} !== 5'b11100) begin n_fail++; $display("FAIL abort_strobes: got %b want 11100", {d0_ce_b, d0_we_b, d0_oe_b, d0_d_en, d0_busy}); end
    d0_req = 1'b0;
    acks = 0;
    repeat (3) begin
      tick();
      if (d0_ack) acks++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      if (d0_ack) acks++;
    end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d acks want 0", acks); end
    run_access(1'b1, 16'h0041, 8'h99, ack, oe, we, den);
    n_checks++; if (ack !== WR_ACK0) begin n_fail++; $display("FAIL post_abort_wr_ack: got %0d want %0d", ack, WR_ACK0); end
    run_access(1'b0, 16'h0041, 8'h00, ack, oe, we, den);
    n_checks++; if ((ack !== 4) || (d0_rdata !== 8'h99)) begin n_fail++; $display("FAIL post_abort_rd: got ack %0d data %h want 4 99", ack, d0_rdata); end
  endtask

`ifdef EMC_XMEM_WBUF_EN
  task automatic test_wbuf();
    int wack, rack;
    logic [7:0] rd;
    preload0(16'h0200, 8'h00);
    tick();
    wack = -1; rack = -1; rd = '0;
    d0_req = 1'b1; d0_we = 1'b1; d0_addr = 16'h0200; d0_wdata = 8'h55;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (d0_ack) begin
        if (wack < 0) begin
          wack = k; d0_we = 1'b0;
        end else if (rack < 0) begin
          rack = k; rd = d0_rdata; d0_req = 1'b0;
        end
      end
      if ((rack > 0) && !d0_busy) break;
    end
    d0_req = 1'b0;
    tick();
    n_checks++; if (wack !== 1) begin n_fail++; $display("FAIL wbuf_wr_ack: got %0d want 1", wack); end
    n_checks++; if (rack !== 8) begin n_fail++; $display("FAIL wbuf_rd_ack: got %0d want 8", rack); end
    n_checks++; if (rd !== 8'h55) begin n_fail++; $display("FAIL wbuf_rd_data: got %h want 55", rd); end
  endtask
`endif

  task automatic test_back_to_back();
    int n;
    int ak[3];
    n = 0;
    ak[0] = 0; ak[1] = 0; ak[2] = 0;
    d1_req = 1'b1; d1_we = 1'b1; d1_addr = 16'h0010; d1_wdata = 8'h11;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (d1_ack && (n < 3)) begin
        ak[n] = k;
        n++;
        if (n == 1) begin d1_addr = 16'h0011; d1_wdata = 8'h22; end
        else if (n == 2) begin d1_addr = 16'h0012; d1_wdata = 8'h33; end
        else d1_req = 1'b0;
      end
      if ((n == 3) && !d1_busy) break;
    end
    d1_req = 1'b0;
    tick();
    n_checks++; if (n !== 3) begin n_fail++; $display("FAIL b2b_ack_count: got %0d want 3", n); end
    n_checks++; if (ak[0] !== WR_ACK1) begin n_fail++; $display("FAIL b2b_first_ack: got %0d want %0d", ak[0], WR_ACK1); end
    n_checks++; if ((ak[1] - ak[0]) !== 7) begin n_fail++; $display("FAIL b2b_spacing1: got %0d want 7", ak[1] - ak[0]); end
    n_checks++; if ((ak[2] - ak[1]) !== 7) begin n_fail++; $display("FAIL b2b_spacing2: got %0d want 7", ak[2] - ak[1]); end
    n_checks++; if ({mem1[16'h0010], mem1[16'h0011], mem1[16'h0012]} !== 24'h112233) begin n_fail++; $display("FAIL b2b_mem: got %h %h %h want 11 22 33", mem1[16'h0010], mem1[16'h0011], mem1[16'h0012]); end
  endtask

  task automatic test_invariants();
    n_checks++; if (viol !== 0) begin n_fail++; $display("FAIL bus_invariants: got %0d violations want 0", viol); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; n_checks = 0; n_fail = 0; viol = 0;
    d0_req = 1'b0; d0_we = 1'b0; d0_addr = '0; d0_wdata = '0;
    d1_req = 1'b0; d1_we = 1'b0; d1_addr = '0; d1_wdata = '0;
    pre0_we = 1'b0; pre0_addr = '0; pre0_data = '0;
    test_reset();
    test_read_turn();
    test_write_readback();
    test_reset_mid_access();
`ifdef EMC_XMEM_WBUF_EN
    test_wbuf();
`endif
    test_back_to_back();
    test_invariants();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
